// File: rtl/hb_pkg.sv
// Heartbeat monitor shared definitions: heartbeat field map, message types,
// FSM encoding and the heartbeat decode helper.
package hb_pkg;

  localparam int EDS_FRAME_EN_POS = 0;
  localparam int EDS_POWER_EN_POS = 1;
  localparam int AOM_POS          = 2;
  localparam int AOM_W            = 12;
  localparam int LASER_OUT_POS    = 14;
  localparam int LASER_CTRL_POS   = 15;
  localparam int FBC_POS          = 16;
  localparam int FBC_W            = 3;
  localparam int PMT_POS          = 19;
  localparam int PMT_W            = 3;
  localparam int FAST_SHUT_POS    = 22;
  localparam int SCAN_POS         = 23;
  localparam int SCAN_W           = 4;
  localparam int MAIN_CNT_POS     = 27;
  localparam int MAIN_CNT_W       = 4;
  localparam int MAP_CNT_POS      = 31;
  localparam int MAP_CNT_W        = 4;
  localparam int RSVD_LSB         = 35;

  localparam int          MSG_TYPE_POS          = 56;
  localparam logic [7:0]  MSG_TYPE_FAST_SHUTTER = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIVE = 2'd1,
    ST_LOST  = 2'd2
  } hb_state_e;

  typedef struct packed {
    logic [SCAN_W-1:0]     scan_state;
    logic                  fast_shutter_state;
    logic [PMT_W-1:0]      pmt_scan_en;
    logic [FBC_W-1:0]      fbc_motor_state;
    logic                  laser_control;
    logic                  laser_out_switch;
    logic [AOM_W-1:0]      laser_aom_voltage;
    logic                  eds_power_en;
    logic                  eds_frame_en;
    logic [MAIN_CNT_W-1:0] main_scan_cnt;
    logic [MAP_CNT_W-1:0]  map_readback_cnt;
  } hb_fields_t;

  function automatic hb_fields_t hb_decode(input logic [63:0] d);
    hb_fields_t f;
    f.scan_state         = d[SCAN_POS +: SCAN_W];
    f.fast_shutter_state = d[FAST_SHUT_POS];
    f.pmt_scan_en        = d[PMT_POS +: PMT_W];
    f.fbc_motor_state    = d[FBC_POS +: FBC_W];
    f.laser_control      = d[LASER_CTRL_POS];
    f.laser_out_switch   = d[LASER_OUT_POS];
    f.laser_aom_voltage  = d[AOM_POS +: AOM_W];
    f.eds_power_en       = d[EDS_POWER_EN_POS];
    f.eds_frame_en       = d[EDS_FRAME_EN_POS];
    f.main_scan_cnt      = d[MAIN_CNT_POS +: MAIN_CNT_W];
    f.map_readback_cnt   = d[MAP_CNT_POS +: MAP_CNT_W];
    return f;
  endfunction

endpackage

// File: rtl/heartbeat_monitor_if.sv
// Heartbeat / action-message strobe bus into the heartbeat monitor.
interface heartbeat_monitor_if;
  logic        heartbeat_en_i;
  logic [63:0] heartbeat_data_i;
  logic        message_up_i;
  logic [63:0] message_up_data_i;

  modport master (output heartbeat_en_i, heartbeat_data_i, message_up_i, message_up_data_i);
  modport slave  (input  heartbeat_en_i, heartbeat_data_i, message_up_i, message_up_data_i);
endinterface

// File: rtl/hb_watchdog.sv
// Millisecond prescaler plus saturating timeout counter; clear_i restarts both.
module hb_watchdog #(
  parameter int MILLISECOND_TIME = 100_000,
  parameter int TIMEOUT_MS       = 1500
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic timeout_o
);
  localparam int MS_W = $clog2(MILLISECOND_TIME + 1);
  localparam int TO_W = $clog2(TIMEOUT_MS + 1);

  logic [MS_W-1:0] ms_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            ms_wrap;

  assign ms_wrap   = (ms_cnt == MS_W'(MILLISECOND_TIME - 1));
  assign timeout_o = (to_cnt == TO_W'(TIMEOUT_MS));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      ms_cnt <= '0;
      to_cnt <= '0;
    end else begin
      ms_cnt <= ms_wrap ? '0 : ms_cnt + 1'b1;
      if (ms_wrap && !timeout_o)
        to_cnt <= to_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/heartbeat_monitor.sv
// Heartbeat link monitor: decodes status heartbeats, watches for link loss and
// handles action messages. Define HB_RESERVED_CHECK_EN to reject heartbeats
// with nonzero reserved bits.
module heartbeat_monitor
  import hb_pkg::*;
#(
  parameter real TCQ              = 0.1,
  parameter int  MILLISECOND_TIME = 100_000,
  parameter int  TIMEOUT_MS       = 1500
) (
  input  logic                clk_i,
  input  logic                rst_i,
  heartbeat_monitor_if.slave  bus,
  output logic                link_alive_o,
  output logic                link_lost_o,
  output logic                status_update_o,
  output logic [3:0]          scan_state_o,
  output logic                fast_shutter_state_o,
  output logic [2:0]          pmt_scan_en_o,
  output logic [2:0]          fbc_motor_state_o,
  output logic                laser_control_o,
  output logic                laser_out_switch_o,
  output logic [11:0]         laser_aom_voltage_o,
  output logic                eds_power_en_o,
  output logic                eds_frame_en_o,
  output logic [3:0]          main_scan_cnt_o,
  output logic [3:0]          map_readback_cnt_o,
  output logic                fast_shutter_req_o,
  output logic                fast_shutter_set_o,
  output logic                msg_unknown_o,
  output logic [15:0]         hb_rx_cnt_o,
  output logic [15:0]         link_lost_cnt_o,
  output logic [7:0]          format_err_cnt_o
);
  hb_state_e  state;
  hb_fields_t fields;
  logic       hb_accept;
  logic       timeout;
  logic       unused_msg;

  assign unused_msg = ^bus.message_up_data_i[MSG_TYPE_POS-1:1];

`ifdef HB_RESERVED_CHECK_EN
  logic hb_reject;
  assign hb_accept = bus.heartbeat_en_i && (bus.heartbeat_data_i[63:RSVD_LSB] == '0);
  assign hb_reject = bus.heartbeat_en_i && (bus.heartbeat_data_i[63:RSVD_LSB] != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      format_err_cnt_o <= '0;
    else if (hb_reject && format_err_cnt_o != 8'hFF)
      format_err_cnt_o <= format_err_cnt_o + 1'b1;
  end
`else
  logic unused_rsvd;
  assign unused_rsvd      = ^bus.heartbeat_data_i[63:RSVD_LSB];
  assign hb_accept        = bus.heartbeat_en_i;
  assign format_err_cnt_o = '0;
`endif

  hb_watchdog #(
    .MILLISECOND_TIME (MILLISECOND_TIME),
    .TIMEOUT_MS       (TIMEOUT_MS)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (hb_accept),
    .timeout_o (timeout)
  );

  // A heartbeat arriving on the expiry edge takes priority over the timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state              <= ST_IDLE;
      fields             <= '0;
      link_alive_o       <= 1'b0;
      link_lost_o        <= 1'b0;
      status_update_o    <= 1'b0;
      fast_shutter_req_o <= 1'b0;
      fast_shutter_set_o <= 1'b0;
      msg_unknown_o      <= 1'b0;
      hb_rx_cnt_o        <= '0;
      link_lost_cnt_o    <= '0;
    end else begin
      link_lost_o        <= 1'b0;
      status_update_o    <= 1'b0;
      fast_shutter_req_o <= 1'b0;
      msg_unknown_o      <= 1'b0;

      if (hb_accept) begin
        state           <= ST_ALIVE;
        link_alive_o    <= 1'b1;
        fields          <= hb_decode(bus.heartbeat_data_i);
        status_update_o <= 1'b1;
        hb_rx_cnt_o     <= hb_rx_cnt_o + 1'b1;
      end else if (state == ST_ALIVE && timeout) begin
        state        <= ST_LOST;
        link_alive_o <= 1'b0;
        link_lost_o  <= 1'b1;
        if (link_lost_cnt_o != 16'hFFFF)
          link_lost_cnt_o <= link_lost_cnt_o + 1'b1;
      end

      if (bus.message_up_i) begin
        if (bus.message_up_data_i[63:MSG_TYPE_POS] == MSG_TYPE_FAST_SHUTTER) begin
          fast_shutter_req_o <= 1'b1;
          fast_shutter_set_o <= bus.message_up_data_i[0];
        end else begin
          msg_unknown_o <= 1'b1;
        end
      end
    end
  end

  assign scan_state_o         = fields.scan_state;
  assign fast_shutter_state_o = fields.fast_shutter_state;
  assign pmt_scan_en_o        = fields.pmt_scan_en;
  assign fbc_motor_state_o    = fields.fbc_motor_state;
  assign laser_control_o      = fields.laser_control;
  assign laser_out_switch_o   = fields.laser_out_switch;
  assign laser_aom_voltage_o  = fields.laser_aom_voltage;
  assign eds_power_en_o       = fields.eds_power_en;
  assign eds_frame_en_o       = fields.eds_frame_en;
  assign main_scan_cnt_o      = fields.main_scan_cnt;
  assign map_readback_cnt_o   = fields.map_readback_cnt;
endmodule

// File: tb/tb_heartbeat_monitor.sv
// Self-checking bench for heartbeat_monitor (MILLISECOND_TIME=10, TIMEOUT_MS=3).
module tb_heartbeat_monitor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  heartbeat_monitor_if bus();

  logic        link_alive, link_lost, status_update;
  logic [3:0]  scan_state;
  logic        fast_shutter_state;
  logic [2:0]  pmt_scan_en, fbc_motor_state;
  logic        laser_control, laser_out_switch;
  logic [11:0] laser_aom_voltage;
  logic        eds_power_en, eds_frame_en;
  logic [3:0]  main_scan_cnt, map_readback_cnt;
  logic        fast_shutter_req, fast_shutter_set, msg_unknown;
  logic [15:0] hb_rx_cnt, link_lost_cnt;
  logic [7:0]  format_err_cnt;

  heartbeat_monitor #(.MILLISECOND_TIME(10), .TIMEOUT_MS(3)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .link_alive_o(link_alive), .link_lost_o(link_lost), .status_update_o(status_update),
    .scan_state_o(scan_state), .fast_shutter_state_o(fast_shutter_state),
    .pmt_scan_en_o(pmt_scan_en), .fbc_motor_state_o(fbc_motor_state),
    .laser_control_o(laser_control), .laser_out_switch_o(laser_out_switch),
    .laser_aom_voltage_o(laser_aom_voltage), .eds_power_en_o(eds_power_en),
    .eds_frame_en_o(eds_frame_en), .main_scan_cnt_o(main_scan_cnt),
    .map_readback_cnt_o(map_readback_cnt), .fast_shutter_req_o(fast_shutter_req),
    .fast_shutter_set_o(fast_shutter_set), .msg_unknown_o(msg_unknown),
    .hb_rx_cnt_o(hb_rx_cnt), .link_lost_cnt_o(link_lost_cnt),
    .format_err_cnt_o(format_err_cnt)
  );

  wire [18:0] misc = {fast_shutter_state, pmt_scan_en, fbc_motor_state, laser_control,
                      laser_out_switch, eds_power_en, eds_frame_en, main_scan_cnt, map_readback_cnt};
  wire [80:0] all_out = {link_alive, link_lost, status_update, scan_state, misc,
                         laser_aom_voltage, fast_shutter_req, fast_shutter_set, msg_unknown,
                         hb_rx_cnt, link_lost_cnt, format_err_cnt};

  typedef struct {
    logic        hb_en;
    logic [63:0] hb_data;
    logic        msg_en;
    logic [63:0] msg_data;
    logic        status;
    logic        alive;
    logic [11:0] aom;
    logic [3:0]  scan;
    logic [18:0] misc;
    logic        fs_req;
    logic        fs_set;
    logic        unk;
    logic [15:0] hbcnt;
  } vec_t;

  vec_t tbl[6];
  vec_t sbq[$];
  vec_t exp_v;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_hb(input logic [63:0] d);
    @(negedge clk);
    bus.heartbeat_en_i   = 1'b1;
    bus.heartbeat_data_i = d;
    @(posedge clk); #1;
    bus.heartbeat_en_i   = 1'b0;
  endtask

  initial begin
    int lost_at, pulses;
    rst = 1'b1;
    bus.heartbeat_en_i = 1'b0; bus.heartbeat_data_i = '0;
    bus.message_up_i   = 1'b0; bus.message_up_data_i = '0;

    //             hb  hb_data                    msg msg_data                   st al aom     scan  misc      req set unk cnt
    tbl[0] = '{1'b1, 64'h0000_0000_07FF_FFFF, 1'b0, 64'h0,                    1, 1, 12'hFFF, 4'hF, 19'h7FF00, 0, 0, 0, 16'd1};
    tbl[1] = '{1'b0, 64'h0,                   1'b0, 64'h0,                    0, 1, 12'hFFF, 4'hF, 19'h7FF00, 0, 0, 0, 16'd1};
    tbl[2] = '{1'b1, 64'h0,                   1'b1, 64'h0100_0000_0000_0001,  1, 1, 12'h000, 4'h0, 19'h00000, 1, 1, 0, 16'd2};
    tbl[3] = '{1'b0, 64'h0,                   1'b1, 64'h0200_0000_0000_0000,  0, 1, 12'h000, 4'h0, 19'h00000, 0, 1, 1, 16'd2};
    tbl[4] = '{1'b1, 64'h0000_0005_2CA8_1694, 1'b1, 64'h0100_0000_0000_0000,  1, 1, 12'h5A5, 4'h9, 19'h2805A, 1, 0, 0, 16'd3};
    tbl[5] = '{1'b0, 64'h0,                   1'b1, 64'hFF00_0000_0000_0001,  0, 1, 12'h5A5, 4'h9, 19'h2805A, 0, 0, 1, 16'd3};

    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", 128'(all_out), 128'd0);
    @(negedge clk) rst = 1'b0;

    repeat (40) @(posedge clk);
    #1 chk("idle_no_timeout_alive", 128'(link_alive), 128'd0);
    chk("idle_no_timeout_lostcnt", 128'(link_lost_cnt), 128'd0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.heartbeat_en_i    = tbl[i].hb_en;
      bus.heartbeat_data_i  = tbl[i].hb_data;
      bus.message_up_i      = tbl[i].msg_en;
      bus.message_up_data_i = tbl[i].msg_data;
      sbq.push_back(tbl[i]);
      @(posedge clk); #1;
      exp_v = sbq.pop_front();
      chk($sformatf("v%0d_status", i), 128'(status_update), 128'(exp_v.status));
      chk($sformatf("v%0d_alive", i),  128'(link_alive),    128'(exp_v.alive));
      chk($sformatf("v%0d_aom", i),    128'(laser_aom_voltage), 128'(exp_v.aom));
      chk($sformatf("v%0d_scan", i),   128'(scan_state),    128'(exp_v.scan));
      chk($sformatf("v%0d_misc", i),   128'(misc),          128'(exp_v.misc));
      chk($sformatf("v%0d_fs_req", i), 128'(fast_shutter_req), 128'(exp_v.fs_req));
      chk($sformatf("v%0d_fs_set", i), 128'(fast_shutter_set), 128'(exp_v.fs_set));
      chk($sformatf("v%0d_unknown", i), 128'(msg_unknown),  128'(exp_v.unk));
      chk($sformatf("v%0d_hbcnt", i),  128'(hb_rx_cnt),     128'(exp_v.hbcnt));
    end
    @(negedge clk);
    bus.heartbeat_en_i = 1'b0; bus.message_up_i = 1'b0;

    // Timeout: one heartbeat then silence, expect loss exactly 31 edges later.
    rst = 1'b1; @(negedge clk) rst = 1'b0;
    send_hb(64'h0000_0000_0000_0028);
    lost_at = 0; pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (link_lost) begin
        pulses++;
        if (lost_at == 0) lost_at = k;
      end
      if (k == 30) chk("alive_before_expiry", 128'(link_alive), 128'd1);
    end
    chk("lost_edge", 128'(lost_at), 128'd31);
    chk("lost_pulse_count", 128'(pulses), 128'd1);
    chk("lost_alive_low", 128'(link_alive), 128'd0);
    chk("lost_cnt", 128'(link_lost_cnt), 128'd1);
    chk("lost_fields_held", 128'(laser_aom_voltage), 128'h00A);

    // LOST -> ALIVE, then heartbeat exactly on the expiry edge wins.
    send_hb(64'h0000_0000_0000_0004);
    chk("revive_alive", 128'(link_alive), 128'd1);
    repeat (30) @(posedge clk);
    send_hb(64'h0000_0000_0000_0008);
    chk("expiry_hb_alive", 128'(link_alive), 128'd1);
    chk("expiry_hb_no_pulse", 128'(link_lost), 128'd0);
    chk("expiry_hb_lostcnt", 128'(link_lost_cnt), 128'd1);
    chk("expiry_hb_rxcnt", 128'(hb_rx_cnt), 128'd3);
    repeat (30) @(posedge clk);
    #1 chk("restart_alive_e30", 128'(link_alive), 128'd1);
    @(posedge clk); #1;
    chk("restart_lost_e31", 128'(link_lost), 128'd1);
    chk("restart_lostcnt", 128'(link_lost_cnt), 128'd2);

    // Reset while ALIVE.
    send_hb(64'h0000_0000_07FF_FFFF);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrun_reset_outputs", 128'(all_out), 128'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("after_reset_no_pulse", 128'(link_lost), 128'd0);

    // Heartbeat with a reserved bit set.
    send_hb(64'h0000_0100_0000_0008);
`ifdef HB_RESERVED_CHECK_EN
    chk("rsvd_fmt_err", 128'(format_err_cnt), 128'd1);
    chk("rsvd_alive", 128'(link_alive), 128'd0);
    chk("rsvd_rxcnt", 128'(hb_rx_cnt), 128'd0);
    chk("rsvd_aom", 128'(laser_aom_voltage), 128'd0);
`else
    chk("rsvd_fmt_err", 128'(format_err_cnt), 128'd0);
    chk("rsvd_alive", 128'(link_alive), 128'd1);
    chk("rsvd_rxcnt", 128'(hb_rx_cnt), 128'd1);
    chk("rsvd_aom", 128'(laser_aom_voltage), 128'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
